// File: rtl/ram_loader_pkg.sv
// ram_loader_pkg: shared types and constants for the input-image RAM loader
package ram_loader_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CHK    = 2'd2,
    ST_FINISH = 2'd3
  } loader_state_t;
  localparam int BITS_PER_BYTE  = 8;
  localparam int IMG_ADDR_WIDTH = 10;
endpackage

// File: rtl/ram_input_loader_byte_unpacker.sv
// byte_unpacker: serialises one byte LSB first into eight consecutive write strobes
module byte_unpacker
  import ram_loader_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     load,
  input  logic [BITS_PER_BYTE-1:0] byte_in,
  output logic                     data,
  output logic                     we,
  output logic                     empty
);
  localparam int CNT_W = $clog2(BITS_PER_BYTE);
  logic [BITS_PER_BYTE-1:0] shreg;
  logic [CNT_W-1:0]         cnt;
  assign empty = cnt == '0;
  // bit0 goes out on the load edge; cnt counts the bits still waiting in shreg
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
      data  <= 1'b0;
      we    <= 1'b0;
    end else if (clr) begin
      shreg <= '0;
      cnt   <= '0;
      we    <= 1'b0;
    end else if (load) begin
      data  <= byte_in[0];
      shreg <= {1'b0, byte_in[BITS_PER_BYTE-1:1]};
      cnt   <= CNT_W'(BITS_PER_BYTE - 1);
      we    <= 1'b1;
    end else if (!empty) begin
      data  <= shreg[0];
      shreg <= shreg >> 1;
      cnt   <= cnt - 1'b1;
      we    <= 1'b1;
    end else
      we <= 1'b0;
endmodule

// File: rtl/ram_input_loader.sv
// ram_input_loader: byte stream to 1-bit image RAM writer; RAM_LOADER_CHKSUM_EN adds a trailing checksum byte
module ram_input_loader
  import ram_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = IMG_ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [BITS_PER_BYTE-1:0] byte_in,
  input  logic                     byte_vld,
  output logic                     byte_rdy,
  output logic                     ram_data,
  output logic [ADDR_WIDTH-1:0]    ram_addr,
  output logic                     ram_we,
  output logic                     busy,
  output logic                     done,
  output logic                     chk_err
);
  loader_state_t         state;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  empty, load, last, go, step;
  assign go   = state == ST_IDLE && start;
  assign last = ram_we && (&ram_addr);
  assign load = state == ST_LOAD && byte_vld && byte_rdy;
  assign step = load || !empty;
  assign busy = state == ST_LOAD || state == ST_CHK;
  assign done = state == ST_FINISH;
`ifdef RAM_LOADER_CHKSUM_EN
  assign byte_rdy = (state == ST_LOAD && empty && !last) || state == ST_CHK;
`else
  assign byte_rdy = state == ST_LOAD && empty && !last;
`endif

  byte_unpacker u_unpack (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (go),
    .load   (load),
    .byte_in(byte_in),
    .data   (ram_data),
    .we     (ram_we),
    .empty  (empty)
  );

  // control FSM; the final write to the top address ends the data phase
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      state <= ST_IDLE;
    else
      case (state)
        ST_IDLE: state <= start ? ST_LOAD : ST_IDLE;
`ifdef RAM_LOADER_CHKSUM_EN
        ST_LOAD: state <= last ? ST_CHK : ST_LOAD;
        ST_CHK:  state <= byte_vld ? ST_FINISH : ST_CHK;
`else
        ST_LOAD: state <= last ? ST_FINISH : ST_LOAD;
`endif
        default: state <= ST_IDLE;
      endcase

  // ram_addr latches the next address with every emitted bit and holds between writes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr     <= '0;
      ram_addr <= '0;
    end else if (go)
      addr <= '0;
    else if (step) begin
      ram_addr <= addr;
      addr     <= addr + 1'b1;
    end

`ifdef RAM_LOADER_CHKSUM_EN
  logic [BITS_PER_BYTE-1:0] sum;
  // running mod-256 sum of data bytes, compared against the trailing checksum byte
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sum     <= '0;
      chk_err <= 1'b0;
    end else if (go) begin
      sum     <= '0;
      chk_err <= 1'b0;
    end else if (load)
      sum <= sum + byte_in;
    else if (state == ST_CHK && byte_vld)
      chk_err <= byte_in != sum;
`else
  assign chk_err = 1'b0;
`endif
endmodule
